// File: rtl/i2c_slave_pkg.sv
// Shared constants for the I2C target register front end.
// FSM encoding, bus levels and the default device address.
package i2c_slave_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_OFFS      = 4'd3;
    localparam logic [3:0] S_OFFS_ACK  = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_MACK      = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h40;
    localparam logic [6:0] GCALL_ADDR   = 7'h00;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stable-level glitch filter.
// Output only follows the input after FILTER_LEN equal samples.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_filt  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target front end with a strobe register port.
// Optional SCL-low bus release: define I2C_SCL_TIMEOUT_EN.
module i2c_slave_regif
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = DEF_DEV_ADDR,
    parameter int          FILTER_LEN     = 3,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic       SYSCLK,
    input  logic       RESET,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WR,
    output logic       REG_RD,
    input  logic [7:0] REG_RDATA,
    output logic       BUSY
);

    logic       w_scl;
    logic       w_sda;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_timeout;
    logic [7:0] w_byte;

    logic [3:0] r_state;
    logic [3:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic       r_phase;
    logic       r_rw;
    logic       r_sda_oe;
    logic [7:0] r_reg_addr;
    logic [7:0] r_wdata;
    logic       r_wr;
    logic       r_rd;
    logic       r_rd_d;
    logic       r_rd_pend;
    logic       r_busy;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .i_clk  (SYSCLK),
        .i_rst  (RESET),
        .i_raw  (SCL_IN),
        .o_filt (w_scl)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .i_clk  (SYSCLK),
        .i_rst  (RESET),
        .i_raw  (SDA_IN),
        .o_filt (w_sda)
    );

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

`ifdef I2C_SCL_TIMEOUT_EN
    logic [19:0] r_to_cnt;

    always_ff @(posedge SYSCLK) begin
        if (RESET || w_scl || !r_busy) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 20'd1;
        end
    end

    assign w_timeout = r_busy && !w_scl &&
                       (r_to_cnt == 20'(TIMEOUT_CYCLES - 20'd1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_tx       <= '0;
            r_phase    <= 1'b0;
            r_rw       <= RW_WRITE;
            r_sda_oe   <= 1'b0;
            r_reg_addr <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_rd_d     <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scl_d   <= w_scl;
            r_sda_d   <= w_sda;
            r_wr      <= 1'b0;
            r_rd      <= r_rd_pend;
            r_rd_pend <= 1'b0;
            r_rd_d    <= r_rd;
            // register file answers one cycle after the strobe
            if (r_rd_d) begin
                r_tx <= REG_RDATA;
            end
            if (r_wr) begin
                r_reg_addr <= r_reg_addr + 8'd1;
            end

            if (w_timeout || w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= '0;
                r_phase  <= 1'b0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= '0;
                                r_phase  <= 1'b0;
                                if (w_byte[7:1] == DEV_ADDR &&
                                    w_byte[7:1] != GCALL_ADDR) begin
                                    r_state <= S_ADDR_ACK;
                                    r_busy  <= 1'b1;
                                    r_rw    <= w_byte[0];
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall && !r_phase) begin
                            r_sda_oe <= ~ACK_LVL;
                            r_phase  <= 1'b1;
                        end else if (w_scl_rise && r_phase) begin
                            if (r_rw == RW_READ) begin
                                r_rd <= 1'b1;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_phase  <= 1'b0;
                            r_bitcnt <= '0;
                            if (r_rw == RW_READ) begin
                                r_sda_oe <= ~r_tx[7];
                                r_state  <= S_RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_OFFS;
                            end
                        end
                    end
                    S_OFFS: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_reg_addr <= w_byte;
                                r_bitcnt   <= '0;
                                r_phase    <= 1'b0;
                                r_state    <= S_OFFS_ACK;
                            end
                        end
                    end
                    S_OFFS_ACK: begin
                        if (w_scl_fall && !r_phase) begin
                            r_sda_oe <= ~ACK_LVL;
                            r_phase  <= 1'b1;
                        end else if (w_scl_fall && r_phase) begin
                            r_sda_oe <= 1'b0;
                            r_phase  <= 1'b0;
                            r_state  <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                r_bitcnt <= '0;
                                r_phase  <= 1'b0;
                                r_state  <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_WDATA_ACK: begin
                        if (w_scl_fall && !r_phase) begin
                            r_wr     <= 1'b1;
                            r_wdata  <= r_shift;
                            r_sda_oe <= ~ACK_LVL;
                            r_phase  <= 1'b1;
                        end else if (w_scl_fall && r_phase) begin
                            r_sda_oe <= 1'b0;
                            r_phase  <= 1'b0;
                            r_state  <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_phase  <= 1'b0;
                                r_state  <= S_MACK;
                            end else begin
                                r_sda_oe <= ~r_tx[6];
                                r_tx     <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    S_MACK: begin
                        if (w_scl_rise && !r_phase) begin
                            if (w_sda == ACK_LVL) begin
                                r_reg_addr <= r_reg_addr + 8'd1;
                                r_rd_pend  <= 1'b1;
                                r_phase    <= 1'b1;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end else if (w_scl_fall && r_phase) begin
                            r_sda_oe <= ~r_tx[7];
                            r_bitcnt <= '0;
                            r_phase  <= 1'b0;
                            r_state  <= S_RDATA;
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SDA_OE    = r_sda_oe;
    assign REG_ADDR  = r_reg_addr;
    assign REG_WDATA = r_wdata;
    assign REG_WR    = r_wr;
    assign REG_RD    = r_rd;
    assign BUSY      = r_busy;

endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
I2C target (slave) front end for the baseboard CPLD. It is the responder to the wishbone I2C master used on the board management bus. It decodes START, device address, register offset and data from filtered SCL/SDA, and drives ACK and read data open-drain. It presents a simple single-cycle strobe register port (offset, write data, read request) to the CPLD register file.

Parameters:
DEV_ADDR, 7'h40, 7-bit target address matched against the first byte after START.
FILTER_LEN, 3, consecutive equal SYSCLK samples needed before filtered SCL/SDA change.
TIMEOUT_CYCLES, 20'd500000, SCL-low limit in SYSCLK cycles; used only with the optional feature.

Ports:
SYSCLK  in  1  system clock.
RESET  in  1  synchronous, active-high reset.
SCL_IN  in  1  raw SCL pin level.
SDA_IN  in  1  raw SDA pin level.
SDA_OE  out  1  1 = pull SDA low; 0 = release.
REG_ADDR  out  8  current register offset.
REG_WDATA  out  8  write data; valid while REG_WR is high.
REG_WR  out  1  one-cycle write strobe.
REG_RD  out  1  one-cycle read request.
REG_RDATA  in  8  read data; valid exactly 1 SYSCLK after REG_RD.
BUSY  out  1  high from a matched address until STOP.

Behaviour:
- Reset: SDA_OE=0, REG_ADDR=0, REG_WDATA=0, REG_WR=0, REG_RD=0, BUSY=0, FSM=IDLE, filters preset to 1.
- Input path: 2-flop synchronizer, then stable filter of FILTER_LEN samples. SCL rise/fall is detected from the filtered SCL and its 1-cycle delayed copy.
- START = filtered SDA falls while SCL is high. STOP = SDA rises while SCL is high. Both are recognised in every state.
  - START (including repeated START) goes to ADDR and clears the bit counter.
  - STOP goes to IDLE, releases SDA_OE and clears BUSY.
- Bit timing:
  - SDA is sampled on the SCL rise, MSB first.
  - SDA_OE changes only on the SCL fall (1 SYSCLK after the fall is detected).
- FSM states: IDLE, ADDR, ADDR_ACK, OFFS, OFFS_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE.
  - ADDR: after 8 bits, if addr[7:1]==DEV_ADDR, go to ADDR_ACK and set BUSY. Otherwise go to IGNORE with no ACK. IGNORE is left only on START or STOP. The general-call address 0 is never acknowledged.
  - ADDR_ACK, write (R/W=0): drive ACK for the 9th clock, then go to OFFS.
  - ADDR_ACK, read (R/W=1): pulse REG_RD with the current REG_ADDR on the 9th SCL rise. Latch REG_RDATA the next cycle. Present bit7 on the following SCL fall, then go to RDATA.
  - OFFS: 8 bits load REG_ADDR. ACK, then go to WDATA.
  - WDATA: after the 8th bit, on the next SCL fall, pulse REG_WR with the current REG_ADDR and the shifted byte, and drive ACK. REG_ADDR increments 1 cycle after REG_WR.
  - RDATA: shift out 8 bits; SDA_OE = ~bit. After the 8th bit, release SDA and go to MACK.
  - MACK: sample master ACK on the 9th SCL rise.
    - ACK (0): increment REG_ADDR, pulse REG_RD 1 cycle later, reload, continue RDATA.
    - NACK: go to IGNORE and wait for STOP.
- REG_ADDR is 8-bit and wraps 0xFF to 0x00. It is retained across transactions, so a write of offset alone followed by a new read transaction reads from that offset.
- REG_WR and REG_RD are never high in the same cycle.
- Reset mid-transfer: SDA_OE is released on the cycle after RESET is sampled high. The FSM returns to IDLE and does not re-enter until the next START.
- Minimum ratio: SCL high/low phases ≥ FILTER_LEN+4 SYSCLK.

Optional Feature:
I2C_SCL_TIMEOUT_EN
- Defined: a 20-bit counter runs while filtered SCL is low and BUSY=1. At TIMEOUT_CYCLES the FSM is forced to IDLE, SDA_OE=0 and BUSY=0. The counter clears on SCL high.
- Undefined: no counter, no forced release; the bus can be held indefinitely.

Decomposition:
- Shared package i2c_slave_pkg: FSM state encoding, ACK/NACK levels, RW_READ/RW_WRITE constants, default DEV_ADDR.
- Sub-module i2c_line_filter (synchronizer plus FILTER_LEN stable filter, preset to 1), instantiated once for SCL and once for SDA.

Test Plan:
- Write 0x80 (addr 0x40, W), 0x50, 0xA5, 0x3C, STOP -> 4 ACKs; REG_WR at 0x50/0xA5 then 0x51/0x3C; REG_ADDR=0x52 afterwards.
- Write 0x80, 0x01, STOP; then 0x81, model returns 0x12 and 0x34, master ACK then NACK -> REG_RD at 0x01 and 0x02; master receives 0x12, 0x34; SDA released after NACK.
- Address 0x7B (W) followed by data -> no ACK on any byte, no REG_WR/REG_RD, BUSY=0.
- Write 0x80, 0xFF, 0x11, 0x22 -> writes at 0xFF then 0x00 (wrap).
- Write 0x80, 0x20, repeated START, 0x81 -> REG_RD at 0x20, no REG_WR issued.
- RESET asserted while ACK is driven -> SDA_OE=0 next cycle, FSM IDLE. With I2C_SCL_TIMEOUT_EN: SCL held low for TIMEOUT_CYCLES mid-byte -> SDA_OE=0, BUSY=0.
